// File: rtl/key_schedule_gen.sv
// Word-serial AES key-schedule generator: one 128-bit round key per stream transfer, buffered in a FIFO.
// Define KEY_SCHED_WIDE_KEY_EN to add AES-192/256; without it every run is AES-128.
module key_sched_sbox (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (t & {8{y[i]}});
            t = xtime(t);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] y;
        y = gf_mul(x, x);
        r = y;
        for (int k = 2; k < 8; k++) begin
            y = gf_mul(y, y);
            r = gf_mul(r, y);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Registered S-box lookup: one cycle of latency
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= 8'h00;
        end else begin
            s <= affine(gf_inv(a));
        end
    end
endmodule

module key_schedule_gen #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         rk_last
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef KEY_SCHED_WIDE_KEY_EN
    localparam int WIN = 8;
`else
    localparam int WIN = 4;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        GEN   = 3'd2,
        SUBW  = 3'd3,
        STALL = 3'd4
    } state_t;

    state_t         state_r, next_state_s, ret_r;
    logic [255:0]   key_r;
    logic [2:0]     nkm1_r, mod_r, next_mod_s;
    logic [3:0]     nr_r, rnd_r;
    logic [7:0]     rcon_r;
    logic [31:0]    win_r [WIN];
    logic [31:0]    asm_r [3];
    logic [1:0]     asm_cnt_r;
    logic [31:0]    sub_in_s, sub_out_s, old_word_s, temp_s, word_s;
    logic           load_s, commit_s, push_s, pop_s, full_s;
    logic           last_word_s, cur_sub_s, next_sub_s;
    logic [127:0]   fifo_data_r [FIFO_DEPTH];
    logic [3:0]     fifo_idx_r  [FIFO_DEPTH];
    logic           fifo_last_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [AW:0]    cnt_r;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Returns {Nk-1, Nr}; key_len 11 and the narrow build fall back to AES-128
    function automatic logic [6:0] mode_cfg(input logic [1:0] kl);
        logic [6:0] cfg;
        case (kl)
`ifdef KEY_SCHED_WIDE_KEY_EN
            2'b01:   cfg = {3'd5, 4'd12};
            2'b10:   cfg = {3'd7, 4'd14};
`else
            2'b01:   cfg = {3'd3, 4'd10};
            2'b10:   cfg = {3'd3, 4'd10};
`endif
            default: cfg = {3'd3, 4'd10};
        endcase
        return cfg;
    endfunction

`ifdef KEY_SCHED_WIDE_KEY_EN
    assign old_word_s = win_r[nkm1_r];
    assign cur_sub_s  = (mod_r == 3'd0) || ((nkm1_r == 3'd7) && (mod_r == 3'd4));
    assign next_sub_s = (next_mod_s == 3'd0) || ((nkm1_r == 3'd7) && (next_mod_s == 3'd4));
`else
    assign old_word_s = win_r[3];
    assign cur_sub_s  = (mod_r == 3'd0);
    assign next_sub_s = (next_mod_s == 3'd0);
`endif

    assign next_mod_s  = (mod_r == nkm1_r) ? 3'd0 : (mod_r + 3'd1);
    // The S-boxes track the newest window word continuously, so their output stays valid across a stall
    assign sub_in_s    = (mod_r == 3'd0) ? {win_r[0][23:0], win_r[0][31:24]} : win_r[0];
    assign temp_s      = cur_sub_s ? (sub_out_s ^ ((mod_r == 3'd0) ? {rcon_r, 24'h000000} : 32'h00000000))
                                   : win_r[0];
    assign word_s      = (state_r == LOAD) ? key_r[255:224] : (old_word_s ^ temp_s);
    assign last_word_s = (rnd_r == nr_r) && (asm_cnt_r == 2'd3);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        key_sched_sbox u_sbox (
            .clk (clk),
            .rst (rst),
            .a   (sub_in_s[8*g +: 8]),
            .s   (sub_out_s[8*g +: 8])
        );
    end

    assign full_s   = (cnt_r == (AW+1)'(FIFO_DEPTH));
    assign rk_valid = (cnt_r != {(AW+1){1'b0}});
    assign pop_s    = rk_valid && rk_ready;
    assign busy     = (state_r != IDLE) || rk_valid;
    assign rk_data  = fifo_data_r[rd_ptr_r];
    assign rk_index = fifo_idx_r[rd_ptr_r];
    assign rk_last  = fifo_last_r[rd_ptr_r];

    // Next-state and word-commit control
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        commit_s     = 1'b0;
        push_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !busy) begin
                    load_s       = 1'b1;
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD, GEN: begin
                if ((asm_cnt_r == 2'd3) && full_s && !pop_s) begin
                    next_state_s = STALL;
                end else begin
                    commit_s = 1'b1;
                    push_s   = (asm_cnt_r == 2'd3);
                    if (state_r == LOAD) begin
                        next_state_s = (mod_r == nkm1_r) ? SUBW : LOAD;
                    end else if (last_word_s) begin
                        next_state_s = IDLE;
                    end else if (next_sub_s) begin
                        next_state_s = SUBW;
                    end else begin
                        next_state_s = GEN;
                    end
                end
            end
            SUBW: next_state_s = GEN;
            STALL: begin
                if (full_s) begin
                    next_state_s = STALL;
                end else begin
                    next_state_s = ret_r;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register, remembering where to resume after a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ret_r   <= IDLE;
        end else begin
            state_r <= next_state_s;
            if ((next_state_s == STALL) && (state_r != STALL)) begin
                ret_r <= state_r;
            end
        end
    end

    // Key window, Rcon, word counters and round-key assembler
    always_ff @(posedge clk) begin
        if (rst) begin
            key_r     <= 256'h0;
            nkm1_r    <= 3'd3;
            nr_r      <= 4'd10;
            mod_r     <= 3'd0;
            rcon_r    <= 8'h01;
            rnd_r     <= 4'd0;
            asm_cnt_r <= 2'd0;
            for (int j = 0; j < WIN; j++) win_r[j] <= 32'h0;
            for (int j = 0; j < 3; j++) asm_r[j] <= 32'h0;
        end else if (load_s) begin
            key_r            <= key_in;
            {nkm1_r, nr_r}   <= mode_cfg(key_len);
            mod_r            <= 3'd0;
            rcon_r           <= 8'h01;
            rnd_r            <= 4'd0;
            asm_cnt_r        <= 2'd0;
        end else if (commit_s) begin
            for (int j = WIN - 1; j > 0; j--) win_r[j] <= win_r[j-1];
            win_r[0] <= word_s;
            mod_r    <= next_mod_s;
            if (state_r == LOAD) begin
                key_r <= {key_r[223:0], 32'h0};
            end
            if ((state_r == GEN) && (mod_r == 3'd0)) begin
                rcon_r <= xtime(rcon_r);
            end
            if (asm_cnt_r == 2'd3) begin
                asm_cnt_r <= 2'd0;
                rnd_r     <= rnd_r + 4'd1;
            end else begin
                asm_r[asm_cnt_r] <= word_s;
                asm_cnt_r        <= asm_cnt_r + 2'd1;
            end
        end
    end

    // Round-key output FIFO; a push and pop together while full is allowed
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                fifo_data_r[j] <= 128'h0;
                fifo_idx_r[j]  <= 4'd0;
                fifo_last_r[j] <= 1'b0;
            end
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            cnt_r    <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= {asm_r[0], asm_r[1], asm_r[2], word_s};
                fifo_idx_r[wr_ptr_r]  <= rnd_r;
                fifo_last_r[wr_ptr_r] <= (rnd_r == nr_r);
                wr_ptr_r              <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
                2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end
endmodule

// File: tb/tb_key_schedule_gen.sv
// Scoreboard bench for key_schedule_gen; follows KEY_SCHED_WIDE_KEY_EN to pick the expected key lengths.
module tb_key_schedule_gen;
`ifdef KEY_SCHED_WIDE_KEY_EN
    localparam bit WIDE = 1'b1;
`else
    localparam bit WIDE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start, rk_ready;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy, rk_valid, rk_last;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [127:0] exp_data[$];
    logic [3:0]   exp_idx[$];
    logic         exp_last[$];
    logic [127:0] obs_data[$];
    logic [3:0]   obs_idx[$];
    logic         obs_last[$];
    int           obs_cyc[$];
    logic [7:0]   sbox_tab [256];

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KALT = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

    key_schedule_gen #(.FIFO_DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_len  (key_len),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_index (rk_index),
        .rk_last  (rk_last)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic int eff_nk(input logic [1:0] kl);
        case (kl)
            2'b01:   return WIDE ? 6 : 4;
            2'b10:   return WIDE ? 8 : 4;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_tab[x] = s;
        end
    endtask

    // Reference FIPS-197 expansion; pushes every round key onto the scoreboard
    task automatic push_expected(input logic [255:0] k, input int nk);
        logic [31:0] w [60];
        logic [7:0]  rc [10];
        logic [31:0] t;
        int nr;
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk - 1], 24'h000000};
            else if (nk == 8 && i % 8 == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            exp_data.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
            exp_idx.push_back(4'(r));
            exp_last.push_back(r == nr);
        end
    endtask

    // Samples mid-cycle, records any transfer, then advances to just after the next edge
    task automatic step();
        @(negedge clk);
        if (rk_valid && rk_ready) begin
            obs_data.push_back(rk_data);
            obs_idx.push_back(rk_index);
            obs_last.push_back(rk_last);
            obs_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic start_run(input logic [255:0] k, input logic [1:0] kl);
        obs_data.delete(); obs_idx.delete(); obs_last.delete(); obs_cyc.delete();
        exp_data.delete(); exp_idx.delete(); exp_last.delete();
        key_in  = k;
        key_len = kl;
        start   = 1'b1;
        cyc     = 0;
        step();
        start   = 1'b0;
    endtask

    task automatic run_until_idle(input int max_cyc, output bit timed_out);
        timed_out = 1'b0;
        for (int n = 0; busy; n++) begin
            if (n >= max_cyc) begin
                timed_out = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rk_ready = 1'b1; key_len = 2'b00; key_in = 256'h0;
        step();
        step();
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (rk_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b exp 0", rk_valid); end
        checks++; if (rk_data !== 128'h0)  begin errors++; $display("FAIL reset_data got %h exp 0", rk_data); end
        checks++; if (rk_index !== 4'd0)   begin errors++; $display("FAIL reset_index got %0d exp 0", rk_index); end
        checks++; if (rk_last !== 1'b0)    begin errors++; $display("FAIL reset_last got %b exp 0", rk_last); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_key_lengths();
        logic [255:0] keys [3];
        logic [127:0] vecs [3];
        logic [1:0]   kls  [3];
        logic [127:0] d, od, last_seen;
        logic [3:0]   ix, oi;
        logic         l, ol;
        int nk, nr, oc, exp_c, last_c;
        bit to;
        keys = '{K128, K192, K256};
        kls  = '{2'b00, 2'b01, 2'b10};
        vecs = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'he98ba06f448c773c8ecc720401002202,
                 128'hfe4890d1e6188d0b046df344706c631e};
        for (int m = 0; m < 3; m++) begin
            nk = eff_nk(kls[m]);
            nr = nk + 6;
            last_c = (nk == 4) ? 55 : ((nk == 6) ? 61 : 74);
            last_seen = 128'h0;
            rk_ready = 1'b1;
            start_run(keys[m], kls[m]);
            push_expected(keys[m], nk);
            run_until_idle(300, to);
            checks++; if (to) begin errors++; $display("FAIL keylen%0d_timeout busy stuck at cycle %0d", m, cyc); end
            checks++; if (cyc != last_c + 1) begin errors++; $display("FAIL keylen%0d_busy_fall got cycle %0d exp %0d", m, cyc, last_c + 1); end
            while (exp_data.size() != 0) begin
                d = exp_data.pop_front(); ix = exp_idx.pop_front(); l = exp_last.pop_front();
                checks++;
                if (obs_data.size() == 0) begin
                    errors++; $display("FAIL keylen%0d_missing round %0d got none exp one", m, ix);
                end else begin
                    od = obs_data.pop_front(); oi = obs_idx.pop_front(); ol = obs_last.pop_front(); oc = obs_cyc.pop_front();
                    last_seen = od;
                    if ({od, oi, ol} !== {d, ix, l}) begin
                        errors++; $display("FAIL keylen%0d_key got %h/%0d/%b exp %h/%0d/%b", m, od, oi, ol, d, ix, l);
                    end
                    exp_c = -1;
                    if (nk == 4) exp_c = 5 + 5 * int'(ix);
                    else if (ix == 4'd0) exp_c = 5;
                    else if (nk == 8 && ix == 4'd1) exp_c = 9;
                    else if (int'(ix) == nr) exp_c = last_c;
                    if (exp_c >= 0) begin
                        checks++;
                        if (oc != exp_c) begin errors++; $display("FAIL keylen%0d_timing round %0d got cycle %0d exp %0d", m, ix, oc, exp_c); end
                    end
                end
            end
            checks++; if (obs_data.size() != 0) begin errors++; $display("FAIL keylen%0d_extra got %0d extra transfers exp 0", m, obs_data.size()); end
            if (nk == 4 + 2 * m) begin
                checks++;
                if (last_seen !== vecs[m]) begin errors++; $display("FAIL keylen%0d_vector got %h exp %h", m, last_seen, vecs[m]); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] k0, d, od;
        logic [3:0] ix, oi;
        logic l, ol;
        bit to;
        rk_ready = 1'b0;
        start_run(K128, 2'b00);
        push_expected(K128, 4);
        k0 = exp_data[0];
        while (cyc < 40) begin
            if (cyc >= 5) begin
                checks++; if (rk_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cycle %0d got %b exp 1", cyc, rk_valid); end
                checks++; if (rk_data !== k0)    begin errors++; $display("FAIL bp_head cycle %0d got %h exp %h", cyc, rk_data, k0); end
            end
            step();
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy got %b exp 1", busy); end
        rk_ready = 1'b1;
        run_until_idle(300, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout busy stuck at cycle %0d", cyc); end
        checks++; if (obs_data.size() != 11) begin errors++; $display("FAIL bp_count got %0d exp 11", obs_data.size()); end
        while (exp_data.size() != 0 && obs_data.size() != 0) begin
            d = exp_data.pop_front(); ix = exp_idx.pop_front(); l = exp_last.pop_front();
            od = obs_data.pop_front(); oi = obs_idx.pop_front(); ol = obs_last.pop_front(); void'(obs_cyc.pop_front());
            checks++;
            if ({od, oi, ol} !== {d, ix, l}) begin errors++; $display("FAIL bp_key got %h/%0d/%b exp %h/%0d/%b", od, oi, ol, d, ix, l); end
        end
        step();
    endtask

    task automatic test_reset_midrun();
        logic [127:0] d, od;
        logic [3:0] ix, oi;
        logic l, ol;
        bit to;
        rk_ready = 1'b1;
        start_run(K256, 2'b10);
        while (cyc < 20) step();
        rst = 1'b1;
        step();
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        checks++; if (rk_valid !== 1'b0)  begin errors++; $display("FAIL midrst_valid got %b exp 0", rk_valid); end
        checks++; if (rk_data !== 128'h0) begin errors++; $display("FAIL midrst_data got %h exp 0", rk_data); end
        checks++; if (rk_index !== 4'd0)  begin errors++; $display("FAIL midrst_index got %0d exp 0", rk_index); end
        checks++; if (rk_last !== 1'b0)   begin errors++; $display("FAIL midrst_last got %b exp 0", rk_last); end
        rst = 1'b0;
        step();
        start_run(K128, 2'b00);
        push_expected(K128, 4);
        run_until_idle(300, to);
        checks++; if (to) begin errors++; $display("FAIL midrst_timeout busy stuck at cycle %0d", cyc); end
        checks++; if (obs_data.size() != 11) begin errors++; $display("FAIL midrst_count got %0d exp 11", obs_data.size()); end
        while (exp_data.size() != 0 && obs_data.size() != 0) begin
            d = exp_data.pop_front(); ix = exp_idx.pop_front(); l = exp_last.pop_front();
            od = obs_data.pop_front(); oi = obs_idx.pop_front(); ol = obs_last.pop_front(); void'(obs_cyc.pop_front());
            checks++;
            if ({od, oi, ol} !== {d, ix, l}) begin errors++; $display("FAIL midrst_key got %h/%0d/%b exp %h/%0d/%b", od, oi, ol, d, ix, l); end
        end
        step();
    endtask

    task automatic test_start_ignored();
        logic [127:0] d, od;
        logic [3:0] ix, oi;
        logic l, ol;
        int oc;
        bit to;
        rk_ready = 1'b1;
        start_run(K128, 2'b00);
        push_expected(K128, 4);
        while (cyc < 10) step();
        key_in = KALT;
        key_len = 2'b10;
        start = 1'b1;
        step();
        start = 1'b0;
        run_until_idle(300, to);
        checks++; if (to) begin errors++; $display("FAIL ign_timeout busy stuck at cycle %0d", cyc); end
        checks++; if (cyc != 56) begin errors++; $display("FAIL ign_busy_fall got cycle %0d exp 56", cyc); end
        checks++; if (obs_data.size() != 11) begin errors++; $display("FAIL ign_count got %0d exp 11", obs_data.size()); end
        while (exp_data.size() != 0 && obs_data.size() != 0) begin
            d = exp_data.pop_front(); ix = exp_idx.pop_front(); l = exp_last.pop_front();
            od = obs_data.pop_front(); oi = obs_idx.pop_front(); ol = obs_last.pop_front(); oc = obs_cyc.pop_front();
            checks++;
            if ({od, oi, ol} !== {d, ix, l}) begin errors++; $display("FAIL ign_key got %h/%0d/%b exp %h/%0d/%b", od, oi, ol, d, ix, l); end
            checks++;
            if (oc != 5 + 5 * int'(ix)) begin errors++; $display("FAIL ign_timing round %0d got cycle %0d exp %0d", ix, oc, 5 + 5 * int'(ix)); end
        end
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rk_ready = 1'b1; key_len = 2'b00; key_in = 256'h0;
        init_sbox();
        test_reset();
        test_key_lengths();
        test_backpressure();
        test_reset_midrun();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_schedule_gen.md
# key_schedule_gen

Parametrised AES key-schedule generator covering AES-128, AES-192 and AES-256, selected at run time. It produces the whole round-key sequence word-serially, using an internally generated Rcon. It emits one 128-bit round key per transfer on a valid/ready stream, buffered in an output FIFO. It sits between the key-load interface and the round datapath, and supports multiple key lengths and back-pressure.

## Interface
- FIFO_DEPTH, 2: round-key output FIFO entries; power of two, ≥2.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  start request; accepted only when busy=0.
- key_len  in  2  00=128, 01=192, 10=256, 11 treated as 128; sampled with accepted start.
- key_in  in  256  cipher key, left-aligned. w0=key_in[255:224]. AES-128 uses [255:128]; AES-192 uses [255:64]. Sampled with accepted start.
- busy  out  1  high from the cycle after an accepted start until the final round key is accepted.
- rk_valid  out  1  FIFO head holds a round key.
- rk_ready  in  1  consumer accepts the head when rk_valid && rk_ready.
- rk_data  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- rk_index  out  4  round number r, 0..Nr.
- rk_last  out  1  rk_index==Nr.

## Operation
- Nk/Nr per mode: 4/10, 6/12, 8/14. Total words are 4(Nr+1): 44, 52, 60.
- The key window holds the last Nk words (8×32 shift register).
- Word i ≥ Nk is computed as w[i]=w[i-Nk]^temp:
  - if i mod Nk==0: temp=SubWord(RotWord(w[i-1]))^{rcon,24'h0}.
  - else if Nk==8 and i mod 8==4: temp=SubWord(w[i-1]).
  - otherwise temp=w[i-1].
- Rcon register: reset and start set it to 8'h01. After each use it is replaced by xtime(rcon), which is a shift left with XOR 8'h1b on carry-out. Sequence: 01,02,04,08,10,20,40,80,1b,36.
- SubWord uses four codebase sbox instances, which are registered with 1-cycle latency.
- Assembler: collects words in order. Every 4th word it pushes {words, r, r==Nr} into the FIFO.
- FSM:
  - IDLE: on start&&!busy, latch key_len and key_in, go to LOAD.
  - LOAD: Nk cycles. Each cycle pushes one key word, in order, into the window and the assembler. Then go to GEN.
  - GEN: computes one word per cycle for words not needing SubWord. For words needing SubWord, go to SUBW first.
  - SUBW: 1 cycle. Drives w[i-1] into the sboxes, then goes to GEN, which consumes the sbox output.
  - STALL: entered whenever the assembler would complete a round key while the FIFO is full. Returns to the interrupted state the cycle after the FIFO is not full.
  - After the last word is written, go to IDLE.
- busy = (state!=IDLE) || FIFO not empty.
- start while busy is ignored, with no effect on the run in progress.
- rk_data, rk_index and rk_last show the FIFO head. The FIFO storage resets to 0.

## Timing
- Reset values: busy=0, rk_valid=0, rk_data=0, rk_index=0, rk_last=0. Internal state: FSM=IDLE, FIFO empty, rcon=8'h01.
- Reset mid-run: all of the above apply on the next cycle, and queued keys are discarded.
- Cycle numbering: start accepted in cycle 0; LOAD begins in cycle 1.
- Round key 0 has rk_valid=1 in cycle 5 in every mode.
- Cost: 1 cycle per plain word, 2 cycles per SubWord word.
- With rk_ready held at 1, the final key appears at:
  - AES-128: cycle 55; round key r appears at cycle 5+5r.
  - AES-192: cycle 61.
  - AES-256: cycle 74; round key 1 at cycle 9.
- A FIFO push and pop in the same cycle is legal when full, and does not stall.
- busy falls in the cycle after the rk_last transfer.
- A new start is accepted from that cycle onward.

## Configuration
- KEY_SCHED_WIDE_KEY_EN defined:
  - AES-192/256 supported as above.
  - Window is 8 words.
- KEY_SCHED_WIDE_KEY_EN not defined:
  - key_len is ignored, and every run is AES-128.
  - key_in[127:0] is unused.
  - Window is 4 words, and the i mod 8==4 SubWord path is removed.
  - AES-128 timing is identical to the defined case.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> 11 transfers. Round key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with rk_last=1 in cycle 55.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 transfers. Last = e98ba06f448c773c8ecc720401002202, rk_index=12, in cycle 61.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> 15 transfers. Last = fe4890d1e6188d0b046df344706c631e, rk_index=14, in cycle 74.
- AES-128 with rk_ready=0 for 40 cycles -> FIFO holds FIFO_DEPTH keys and the FSM sits in STALL. rk_data stays round key 0 throughout. After release, all 11 keys are correct and in order.
- Reset asserted at cycle 20 of an AES-256 run, then a new AES-128 start -> outputs are 0 the cycle after reset. The new run matches the AES-128 vectors, with rcon restarting at 01.
- start pulsed at cycle 10 of an AES-128 run with a different key -> ignored. The original sequence is unchanged, and busy falls after rk_last.
